// File: rtl/fetch_aligner_pkg.sv
// Shared types and constants for the fetch aligner.
// Latency: n/a. Backpressure: n/a.
package fetch_aligner_pkg;

    localparam int FETCH_ALIGNER_QUEUE_DEPTH = 4;
    localparam int FA_VADDR_WIDTH            = 32;
    localparam int FA_LINE_WIDTH             = 128;

    typedef logic [15:0] halfword_t;

    typedef enum logic [1:0] {
        RUN,
        FAULT,
        HALT
    } aligner_state_e;

    typedef struct packed {
        logic [FA_VADDR_WIDTH-1:0] pc;
        logic [FA_LINE_WIDTH-1:0]  line;
        logic                      fault;
    } fetch_packet_t;

endpackage

// File: rtl/fetch_aligner_if.sv
// Fetch-side and decode-side buses of the fetch aligner.
// Latency: n/a. Backpressure: in_stall towards fetch, out_stall from decode.
interface fetch_aligner_if #(
    parameter int LINE_WIDTH  = 128,
    parameter int VADDR_WIDTH = 32
);
    logic                   in_valid;
    logic                   in_fault;
    logic [VADDR_WIDTH-1:0] in_pc;
    logic [LINE_WIDTH-1:0]  in_line;
    logic                   in_stall;
    logic                   out_valid;
    logic [31:0]            out_insn;
    logic [VADDR_WIDTH-1:0] out_pc;
    logic                   out_compressed;
    logic                   out_fault;
    logic                   out_stall;

    modport master (
        output in_valid, in_fault, in_pc, in_line, out_stall,
        input  in_stall, out_valid, out_insn, out_pc, out_compressed, out_fault
    );

    modport slave (
        input  in_valid, in_fault, in_pc, in_line, out_stall,
        output in_stall, out_valid, out_insn, out_pc, out_compressed, out_fault
    );
endinterface

// File: rtl/fetch_aligner_halfword_queue.sv
// Shift queue of halfwords: push 0..2 at the tail, pop 0..2 from the head per cycle.
// Latency: 1 cycle push-to-head. Backpressure: none; caller guarantees no overflow/underflow.
module fetch_aligner_halfword_queue
    import fetch_aligner_pkg::*;
#(
    parameter int DEPTH = FETCH_ALIGNER_QUEUE_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic [1:0]           push_cnt_i,
    input  halfword_t [1:0]      push_dat_i,
    input  logic [1:0]           pop_cnt_i,
    output halfword_t [1:0]      head_o,
    output logic [2:0]           count_o
);

    halfword_t [DEPTH-1:0] q_q, q_d;
    logic [2:0]            count_q, count_d;

    always_comb begin
        int src;
        int slot;
        src     = 0;
        slot    = 0;
        q_d     = q_q;
        count_d = count_q - {1'b0, pop_cnt_i} + {1'b0, push_cnt_i};
        for (int i = 0; i < DEPTH; i++) begin
            // Surviving entries slide down by the pop amount; pushes land right behind them.
            src  = i + int'(pop_cnt_i);
            slot = i - (int'(count_q) - int'(pop_cnt_i));
            if (src < int'(count_q)) begin
                q_d[i] = q_q[src[1:0]];
            end else if (slot >= 0 && slot < int'(push_cnt_i)) begin
                q_d[i] = push_dat_i[slot[0]];
            end
        end
        if (clr_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            count_q <= '0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
        end
    end

    assign head_o  = q_q[1:0];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// Realigns fetch packets into one 16/32-bit instruction per cycle; RVC via RAFI_FETCH_ALIGNER_RVC_EN.
// Latency: 1 cycle packet-to-output. Backpressure: in_stall from registers only (count>2 or not RUN).
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter int LINE_WIDTH  = 128,
    parameter int VADDR_WIDTH = 32,
    parameter int QUEUE_DEPTH = FETCH_ALIGNER_QUEUE_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    fetch_aligner_if.slave bus
);

    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    aligner_state_e         state_q, state_d;
    logic [VADDR_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [VADDR_WIDTH-1:0] fault_pc_q, fault_pc_d;

    logic [2:0]       count;
    halfword_t [1:0]  head;
    halfword_t [1:0]  push_dat;
    logic [1:0]       push_cnt, pop_cnt;
    logic             clr;
    logic [31:0]      word;
    logic             compressed, complete, misaligned, accept;

    assign word = bus.in_line[{bus.in_pc[OFF_W-1:2], 5'b0} +: 32];

`ifdef RAFI_FETCH_ALIGNER_RVC_EN
    assign compressed = (head[0][1:0] != 2'b11);
    assign misaligned = 1'b0;
`else
    assign compressed = 1'b0;
    assign misaligned = bus.in_pc[1];
`endif

    assign complete     = ((count >= 3'd1) & compressed) | (count >= 3'd2);
    assign bus.in_stall = (count > 3'd2) | (state_q != RUN);
    assign accept       = bus.in_valid & ~bus.in_stall & ~flush;

    always_comb begin
        state_d            = state_q;
        head_pc_d          = head_pc_q;
        fault_pc_d         = fault_pc_q;
        bus.out_valid      = 1'b0;
        bus.out_fault      = 1'b0;
        bus.out_pc         = head_pc_q;
        bus.out_insn       = compressed ? {16'h0, head[0]} : {head[1], head[0]};
        bus.out_compressed = 1'b0;
        pop_cnt            = 2'd0;
        push_cnt           = 2'd0;
        push_dat           = {word[31:16], word[31:16]};
        clr                = 1'b0;

        unique case (state_q)
            RUN: bus.out_valid = complete;
            FAULT: begin
                // Whole instructions ahead of the fault retire first; a dangling
                // 32-bit low half reports the fault under its own pc.
                bus.out_valid = 1'b1;
                bus.out_fault = ~complete;
                if (~complete && count == 3'd0) begin
                    bus.out_pc = fault_pc_q;
                end
            end
            default: ;
        endcase

        if (flush) begin
            bus.out_valid = 1'b0;
        end
        bus.out_compressed = bus.out_valid & ~bus.out_fault & compressed;

        if (bus.out_valid && !bus.out_stall) begin
            if (bus.out_fault) begin
                state_d = HALT;
                clr     = 1'b1;
            end else begin
                pop_cnt   = compressed ? 2'd1 : 2'd2;
                head_pc_d = head_pc_q + (compressed ? VADDR_WIDTH'(2) : VADDR_WIDTH'(4));
            end
        end

        if (accept) begin
            if (bus.in_fault || misaligned) begin
                state_d    = FAULT;
                fault_pc_d = bus.in_pc;
            end else begin
                push_cnt = bus.in_pc[1] ? 2'd1 : 2'd2;
                push_dat = bus.in_pc[1] ? {word[31:16], word[31:16]} : {word[31:16], word[15:0]};
                if (count == {1'b0, pop_cnt}) begin
                    head_pc_d = bus.in_pc;
                end
            end
        end

        if (flush) begin
            state_d = RUN;
            clr     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            head_pc_q  <= '0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            head_pc_q  <= head_pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_aligner_halfword_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .push_cnt_i (push_cnt),
        .push_dat_i (push_dat),
        .pop_cnt_i  (pop_cnt),
        .head_o     (head),
        .count_o    (count)
    );

`ifndef SYNTHESIS
    // Fetch must deliver packets that continue exactly where the queue tail ends.
    a_contiguous: assert property (@(posedge clk) disable iff (!rst_n)
        (accept && count != 3'd0) |-> (bus.in_pc == head_pc_q + VADDR_WIDTH'({count, 1'b0})));
`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// Randomized and directed checks of fetch_aligner against a halfword-queue reference model.
module tb_fetch_aligner;

`ifdef RAFI_FETCH_ALIGNER_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    localparam int M_RUN   = 0;
    localparam int M_FAULT = 1;
    localparam int M_HALT  = 2;

    logic clk;
    logic rst_n;
    logic flush;

    fetch_aligner_if bus_if ();

    fetch_aligner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hw;
        logic [31:0] pc;
    } mhw_t;

    mhw_t        mq[$];
    int          mstate;
    logic [31:0] fpc;
    int          n_checks;
    int          n_fail;
    logic [31:0] next_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] mkline(input logic [31:0] pc, input logic [31:0] w);
        logic [127:0] l;
        l = {$urandom, $urandom, $urandom, $urandom};
        l[32*int'(pc[3:2]) +: 32] = w;
        return l;
    endfunction

    // Drive one cycle at the negedge, check outputs, then advance the model past the posedge.
    task automatic cycle(input logic v, input logic f, input logic [31:0] pc,
                         input logic [127:0] line, input logic os, input logic fl,
                         output logic acc);
        logic        comp, complete, e_stall, e_valid, e_fault;
        logic [31:0] e_pc, e_insn, w;
        logic [15:0] h0, h1;
        int          n;
        bus_if.in_valid  = v;
        bus_if.in_fault  = f;
        bus_if.in_pc     = pc;
        bus_if.in_line   = line;
        bus_if.out_stall = os;
        flush            = fl;
        #1;
        n        = mq.size();
        h0       = (n >= 1) ? mq[0].hw : 16'h0;
        h1       = (n >= 2) ? mq[1].hw : 16'h0;
        comp     = RVC && (n >= 1) && (h0[1:0] != 2'b11);
        complete = (n >= 1 && comp) || (n >= 2);
        e_stall  = (n > 2) || (mstate != M_RUN);
        e_valid  = 1'b0;
        e_fault  = 1'b0;
        if (!fl && mstate == M_RUN) e_valid = complete;
        if (!fl && mstate == M_FAULT) begin
            e_valid = 1'b1;
            e_fault = !complete;
        end
        check("in_stall", bus_if.in_stall, e_stall);
        check("out_valid", bus_if.out_valid, e_valid);
        if (e_valid) begin
            check("out_fault", bus_if.out_fault, e_fault);
            if (e_fault) e_pc = (n == 1) ? mq[0].pc : fpc;
            else         e_pc = mq[0].pc;
            check("out_pc", bus_if.out_pc, e_pc);
            if (!e_fault) begin
                e_insn = comp ? {16'h0, h0} : {h1, h0};
                check("out_insn", bus_if.out_insn, e_insn);
                check("out_compressed", bus_if.out_compressed, comp);
            end
        end

        acc = v && !e_stall && !fl;
        if (fl) begin
            mq.delete();
            mstate = M_RUN;
        end else begin
            if (e_valid && !os) begin
                if (e_fault) begin
                    mq.delete();
                    mstate = M_HALT;
                end else begin
                    void'(mq.pop_front());
                    if (!comp) void'(mq.pop_front());
                end
            end
            if (acc) begin
                if (f || (!RVC && pc[1])) begin
                    mstate = M_FAULT;
                    fpc    = pc;
                end else begin
                    w = line[32*int'(pc[3:2]) +: 32];
                    if (!pc[1]) mq.push_back('{hw: w[15:0], pc: {pc[31:2], 2'b00}});
                    mq.push_back('{hw: w[31:16], pc: {pc[31:2], 2'b10}});
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic os);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 128'h0, os, 1'b0, a);
    endtask

    task automatic do_flush();
        logic a;
        cycle(1'b0, 1'b0, 32'h0, 128'h0, 1'b0, 1'b1, a);
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        flush            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_fault  = 1'b0;
        bus_if.in_pc     = '0;
        bus_if.in_line   = '0;
        bus_if.out_stall = 1'b0;
        #1;
        check("rst_out_valid", bus_if.out_valid, 1'b0);
        check("rst_in_stall", bus_if.in_stall, 1'b0);
        check("rst_out_fault", bus_if.out_fault, 1'b0);
        check("rst_out_compressed", bus_if.out_compressed, 1'b0);
        check("rst_out_insn", bus_if.out_insn, 32'h0);
        check("rst_out_pc", bus_if.out_pc, 32'h0);
        mq.delete();
        mstate = M_RUN;
        fpc    = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        a, v, f, os, fl;
        logic [31:0] pc;
        n_checks = 0;
        n_fail   = 0;
        mstate   = M_RUN;
        fpc      = '0;
        rst_n    = 1'b1;
        flush    = 1'b0;
        #2;
        do_reset();

        // Sequential 32-bit code.
        cycle(1, 0, 32'h8000_0000, mkline(32'h8000_0000, 32'h0000_0013), 0, 0, a);
        cycle(1, 0, 32'h8000_0004, mkline(32'h8000_0004, 32'h0000_0013), 0, 0, a);
        cycle(1, 0, 32'h8000_0008, mkline(32'h8000_0008, 32'h0000_0013), 0, 0, a);
        idle(3, 0);

        // Mixed RVC: c.nop then a 32-bit instruction straddling two words.
        do_flush();
        cycle(1, 0, 32'h8000_0000, mkline(32'h8000_0000, 32'h00A3_0001), 0, 0, a);
        cycle(1, 0, 32'h8000_0004, mkline(32'h8000_0004, 32'h1234_0001), 0, 0, a);
        idle(4, 0);

        // 32-bit instruction straddling a line boundary.
        do_flush();
        cycle(1, 0, 32'h8000_000E, mkline(32'h8000_000E, 32'h0513_5555), 0, 0, a);
        cycle(1, 0, 32'h8000_0010, mkline(32'h8000_0010, 32'h4011_0000), 0, 0, a);
        idle(4, 0);

        // Backpressure fills the queue, then drains.
        do_flush();
        pc = 32'h8000_0000;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, pc, mkline(pc, $urandom | 32'h0003_0003), 1, 0, a);
            if (a) pc = pc + 32'd4;
        end
        idle(6, 0);

        // Fault right behind the low half of a 32-bit instruction.
        do_flush();
        cycle(1, 0, 32'h8000_0FFE, mkline(32'h8000_0FFE, 32'h0513_2222), 0, 0, a);
        cycle(1, 1, 32'h8000_1000, mkline(32'h8000_1000, 32'h0000_0000), 0, 0, a);
        idle(5, 0);
        do_flush();

        // Flush with a simultaneous packet while three halfwords are queued.
        cycle(1, 0, 32'h8000_0002, mkline(32'h8000_0002, 32'h0513_7777), 1, 0, a);
        cycle(1, 0, 32'h8000_0004, mkline(32'h8000_0004, 32'h0001_4501), 1, 0, a);
        cycle(1, 0, 32'h8000_0008, mkline(32'h8000_0008, 32'h0000_0013), 1, 1, a);
        cycle(1, 0, 32'h8000_0100, mkline(32'h8000_0100, 32'h0000_0013), 0, 0, a);
        idle(3, 0);

        // Randomized traffic with occasional faults, flushes and a mid-run reset.
        do_flush();
        next_pc = 32'h8000_2000;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset();
                next_pc = 32'h8000_4000;
            end
            fl = (mstate == M_HALT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 39) == 0);
            os = ($urandom_range(0, 2) == 0);
            pc = next_pc;
            cycle(v, f, pc, {$urandom, $urandom, $urandom, $urandom}, os, fl, a);
            if (fl) begin
                next_pc = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
            end else if (a && !f) begin
                next_pc = pc + (pc[1] ? 32'd2 : 32'd4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
